// File: rtl/dbus_sched_if.sv
// Data-bus scheduler types and port bundle.
// dbus_sched_pkg holds the request/response structs; dbus_sched_if groups the two requester
// ports, the external bus port and the per-port stalls.
package dbus_sched_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

interface dbus_sched_if;
  import dbus_sched_pkg::*;

  dbus_req_t  req0;
  dbus_req_t  req1;
  dbus_resp_t resp0;
  dbus_resp_t resp1;
  logic       stall0;
  logic       stall1;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  // Scheduler side.
  modport slave (
    input  req0, req1, dresp,
    output resp0, resp1, stall0, stall1, dreq
  );

  // Requesters plus external bus model side.
  modport master (
    output req0, req1, dresp,
    input  resp0, resp1, stall0, stall1, dreq
  );

endinterface

// File: rtl/dbus_sched.sv
// Two-port data-bus scheduler.
// Grants one of two requesters, issues a registered copy of its request on the split
// addr_ok/data_ok handshake, routes the completion back to the owner and stalls each port
// while its request is outstanding.
// Optional feature: define DBUS_SCHED_RR_EN for round-robin arbitration on ties; the default
// build uses fixed priority with port 0 winning.
module dbus_sched
  import dbus_sched_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  dbus_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q,  last_d;
  dbus_req_t  lreq_q,  lreq_d;

  logic       winner;
  logic       complete;
  dbus_resp_t owner_resp;

  // Arbitration: pick the port to grant when leaving IDLE.
  always_comb begin
    winner = 1'b0;
`ifdef DBUS_SCHED_RR_EN
    if (bus.req0.valid && bus.req1.valid) begin
      winner = ~last_q;
    end else begin
      winner = ~bus.req0.valid;
    end
`else
    winner = ~bus.req0.valid;
`endif
  end

  // Next-state logic: grant, address phase, data phase.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    lreq_d   = lreq_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req0.valid || bus.req1.valid) begin
          owner_d = winner;
          lreq_d  = winner ? bus.req1 : bus.req0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        // data_ok without addr_ok is ignored here.
        if (bus.dresp.addr_ok) begin
          if (bus.dresp.data_ok) begin
            complete = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d  = StData;
          end
        end
      end
      StData: begin
        if (bus.dresp.data_ok) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
`ifdef DBUS_SCHED_RR_EN
    if (complete) begin
      last_d = owner_q;
    end
`endif
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      lreq_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lreq_q  <= lreq_d;
    end
  end

  // Bus request and response routing; only the owner ever sees a non-zero response.
  always_comb begin
    bus.dreq           = lreq_q;
    bus.dreq.valid     = (state_q == StAddr);
    owner_resp         = '0;
    owner_resp.addr_ok = (state_q == StAddr) & bus.dresp.addr_ok;
    owner_resp.data_ok = complete;
    owner_resp.data    = complete ? bus.dresp.data : '0;
    bus.resp0          = owner_q ? '0 : owner_resp;
    bus.resp1          = owner_q ? owner_resp : '0;
  end

  // Per-port stall: hold while valid until the completing cycle.
  always_comb begin
    bus.stall0 = bus.req0.valid & ~bus.resp0.data_ok;
    bus.stall1 = bus.req1.valid & ~bus.resp1.data_ok;
  end

endmodule

// File: tb/tb_dbus_sched.sv
// Randomized scoreboard bench for dbus_sched.
// The stimulus process plays both requesters and the external bus, keeps a transaction-level
// model of grants and completions, and pushes each expected completion into a queue; a
// separate monitor compares the per-port responses and stalls every cycle.
module tb_dbus_sched;
  import dbus_sched_pkg::*;

  logic clk = 1'b0;
  logic resetn;

  dbus_sched_if bus ();

  dbus_sched dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sq[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  bit          run_mon = 1'b0;
  bit          in_reset = 1'b0;
  bit          gen_en = 1'b1;

  // Transaction-level model state.
  bit          busy = 1'b0;
  bit          addr_done = 1'b0;
  logic        m_owner = 1'b0;
  logic        m_last = 1'b1;
  dbus_req_t   granted = '0;
  dbus_req_t   r [2];
  bit          withdrawn [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic dbus_req_t rand_req();
    dbus_req_t q;
    q.valid  = 1'b1;
    q.addr   = $urandom;
    q.size   = 3'($urandom_range(0, 2));
    q.strobe = 4'($urandom);
    q.data   = $urandom;
    return q;
  endfunction

  function automatic logic pick_winner(input logic v0, input logic v1);
`ifdef DBUS_SCHED_RR_EN
    if (v0 && v1) return ~m_last;
`endif
    return ~v0;
  endfunction

  // One bus cycle. mode 0: random bus; 1: addr_ok only, never data_ok; 2: stray data_ok only.
  task automatic step(input int mode);
    logic aok, dok, w;
    @(negedge clk);
    cyc++;
    check("dreq_valid", bus.dreq.valid, busy && !addr_done);
    if (busy) begin
      check("dreq_fields", {bus.dreq.addr, bus.dreq.size, bus.dreq.strobe, bus.dreq.data},
            {granted.addr, granted.size, granted.strobe, granted.data});
    end
    for (int k = 0; k < 2; k++) begin
      if (gen_en && !r[k].valid && !withdrawn[k] && $urandom_range(0, 99) < 60) begin
        r[k] = rand_req();
      end else if (gen_en && r[k].valid && busy && m_owner == 1'(k) &&
                   $urandom_range(0, 99) < 5) begin
        r[k].valid   = 1'b0;
        withdrawn[k] = 1'b1;
      end
    end
    aok = 1'b0;
    dok = 1'b0;
    if (mode == 1) begin
      aok = busy && !addr_done;
    end else if (mode == 2) begin
      dok = 1'b1;
    end else if (busy && !addr_done) begin
      aok = ($urandom_range(0, 99) < 40);
      dok = aok ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
    end else if (busy) begin
      dok = ($urandom_range(0, 99) < 40);
    end else begin
      aok = ($urandom_range(0, 99) < 10);
      dok = ($urandom_range(0, 99) < 10);
    end
    bus.dresp = '{addr_ok: aok, data_ok: dok, data: $urandom};
    bus.req0  = r[0];
    bus.req1  = r[1];
    // End-of-cycle model update.
    if (busy) begin
      if ((!addr_done && aok && dok) || (addr_done && dok)) begin
        sq.push_back('{cyc: cyc, port: m_owner, data: bus.dresp.data});
        busy = 1'b0;
`ifdef DBUS_SCHED_RR_EN
        m_last = m_owner;
`endif
        r[m_owner].valid   = 1'b0;
        withdrawn[m_owner] = 1'b0;
      end else if (!addr_done && aok) begin
        addr_done = 1'b1;
      end
    end else if (r[0].valid || r[1].valid) begin
      w         = pick_winner(r[0].valid, r[1].valid);
      busy      = 1'b1;
      addr_done = 1'b0;
      m_owner   = w;
      granted   = r[w];
    end
  endtask

  // Monitor: compare responses and stalls against the scoreboard.
  initial begin
    exp_t e;
    bit   hit;
    logic port, exp0, exp1;
    wait (run_mon);
    forever begin
      @(negedge clk);
      #4;
      if (in_reset) continue;
      while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
      hit  = (sq.size() > 0 && sq[0].cyc == cyc);
      port = hit ? sq[0].port : 1'b0;
      exp0 = hit && !port;
      exp1 = hit && port;
      check("resp0_data_ok", bus.resp0.data_ok, exp0);
      check("resp1_data_ok", bus.resp1.data_ok, exp1);
      check("stall0", bus.stall0, bus.req0.valid & ~exp0);
      check("stall1", bus.stall1, bus.req1.valid & ~exp1);
      if (hit) begin
        e = sq.pop_front();
        if (!e.port) begin
          check("resp0_data", bus.resp0.data, e.data);
          check("resp1_quiet", bus.resp1, '0);
        end else begin
          check("resp1_data", bus.resp1.data, e.data);
          check("resp0_quiet", bus.resp0, '0);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int n;
    r[0] = '0;
    r[1] = '0;
    withdrawn[0] = 1'b0;
    withdrawn[1] = 1'b0;
    resetn    = 1'b0;
    bus.req0  = rand_req();
    bus.req1  = '0;
    bus.dresp = '0;
    #3;
    check("rst_dreq", bus.dreq, '0);
    check("rst_resp0", bus.resp0, '0);
    check("rst_resp1", bus.resp1, '0);
    check("rst_stall0", bus.stall0, 1'b1);
    check("rst_stall1", bus.stall1, 1'b0);
    bus.req0 = '0;
    @(negedge clk);
    resetn  = 1'b1;
    run_mon = 1'b1;

    for (int i = 0; i < 3000; i++) step(0);

    // Drain outstanding work.
    gen_en = 1'b0;
    r[0].valid = 1'b0;
    r[1].valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      step(0);
      n++;
    end
    check("drain_timeout", busy, 1'b0);
    step(0);

    // Reset while waiting for data_ok, then a late data_ok.
    r[0] = rand_req();
    n = 0;
    while (!(busy && addr_done) && n < 50) begin
      step(1);
      n++;
    end
    check("reach_data_timeout", busy && addr_done, 1'b1);
    @(negedge clk);
    cyc++;
    bus.dresp = '0;
    in_reset  = 1'b1;
    resetn    = 1'b0;
    #1;
    check("mid_rst_dreq_valid", bus.dreq.valid, 1'b0);
    check("mid_rst_resp0", bus.resp0, '0);
    check("mid_rst_resp1", bus.resp1, '0);
    busy      = 1'b0;
    addr_done = 1'b0;
    m_last    = 1'b1;
    r[0]      = '0;
    r[1]      = '0;
    bus.req0  = '0;
    bus.req1  = '0;
    @(negedge clk);
    cyc++;
    resetn   = 1'b1;
    in_reset = 1'b0;
    // Late and stray data_ok with nothing outstanding.
    for (int i = 0; i < 4; i++) step(2);

    // A fresh transaction still works after the reset.
    gen_en = 1'b1;
    for (int i = 0; i < 200; i++) step(0);
    gen_en = 1'b0;
    r[0].valid = 1'b0;
    r[1].valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      step(0);
      n++;
    end
    check("final_drain_timeout", busy, 1'b0);
    step(0);
    step(0);
    check("scoreboard_empty", 32'(sq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
